input_command_arbiter: RTL and testbench

- Menu/cursor controller fed by two active-low command sources: the debounced IR receiver lines (deb_ir_*) and the debounced front-panel pushbuttons (btn_*).
- Arbitrates between the two sources and emits exactly one command per press, with a release-plus-guard lockout.
- Maintains the wrapping menu cursor and the latched selection consumed by the display/game logic.

---
 rtl/input_command_arbiter_pkg.sv | 12 +
 rtl/input_command_arbiter_cmd_prio_enc.sv | 16 +
 rtl/input_command_arbiter.sv | 112 +++++++++++
 tb/tb_input_command_arbiter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/input_command_arbiter_pkg.sv
// input_command_arbiter_pkg: command, source and state encodings shared by the arbiter
package input_command_arbiter_pkg;
  localparam logic [1:0] CMD_LEFT  = 2'd0;
  localparam logic [1:0] CMD_RIGHT = 2'd1;
  localparam logic [1:0] CMD_SEL   = 2'd2;
  localparam logic [1:0] CMD_RST   = 2'd3;
  localparam logic SRC_BTN = 1'b0;
  localparam logic SRC_IR  = 1'b1;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_HOLD  = 2'd1;
  localparam logic [1:0] ST_GUARD = 2'd2;
endpackage

// File: rtl/input_command_arbiter_cmd_prio_enc.sv
// cmd_prio_enc: folds four active-low command lines into an active flag and a code
module cmd_prio_enc
  import input_command_arbiter_pkg::*;
(
  input  logic       left_n,
  input  logic       right_n,
  input  logic       sel_n,
  input  logic       rst_n,
  output logic       active,
  output logic [1:0] code
);
  always_comb begin
    active = ~(left_n & right_n & sel_n & rst_n);
    code   = !rst_n ? CMD_RST : !sel_n ? CMD_SEL : !left_n ? CMD_LEFT : CMD_RIGHT;
  end
endmodule

// File: rtl/input_command_arbiter.sv
// input_command_arbiter: two-source command arbiter with press lockout, menu cursor and selection
module input_command_arbiter
  import input_command_arbiter_pkg::*;
#(
  parameter int NUM_ITEMS      = 8,
  parameter int CUR_W          = 3,
  parameter int LOCKOUT_CYCLES = 1000000,
  parameter int LOCK_W         = 20
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             deb_ir_left,
  input  logic             deb_ir_right,
  input  logic             deb_ir_sel,
  input  logic             deb_ir_rst,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_sel,
  input  logic             btn_rst,
  output logic             cmd_valid,
  output logic [1:0]       cmd_code,
  output logic             cmd_src,
  output logic [CUR_W-1:0] cursor,
  output logic [CUR_W-1:0] sel_item,
  output logic             sel_valid,
  output logic             busy
);
  localparam logic [CUR_W-1:0] LAST = CUR_W'(NUM_ITEMS - 1);
  localparam logic [CUR_W-1:0] ONE  = CUR_W'(1);
  logic             btn_act, ir_act, any_low, fire, gnt_src;
  logic [1:0]       btn_code, ir_code, gnt_code;
  logic [1:0]       state_q, state_d;
  logic [LOCK_W-1:0] cnt_q, cnt_d;
  logic             last_src_q, last_src_d;
  logic             cmd_valid_q, cmd_valid_d, cmd_src_q, cmd_src_d;
  logic [1:0]       cmd_code_q, cmd_code_d;
  logic [CUR_W-1:0] cursor_q, cursor_d, sel_item_q, sel_item_d;
  logic             sel_valid_q, sel_valid_d;

  cmd_prio_enc u_btn (.left_n(btn_left), .right_n(btn_right), .sel_n(btn_sel),
                      .rst_n(btn_rst), .active(btn_act), .code(btn_code));
  cmd_prio_enc u_ir  (.left_n(deb_ir_left), .right_n(deb_ir_right), .sel_n(deb_ir_sel),
                      .rst_n(deb_ir_rst), .active(ir_act), .code(ir_code));

  always_comb begin
    any_low  = btn_act | ir_act;
    // on a tie the source that did not win last time gets the grant
    gnt_src  = (btn_act & ir_act) ? ~last_src_q : (ir_act ? SRC_IR : SRC_BTN);
    gnt_code = gnt_src ? ir_code : btn_code;
    fire     = (state_q == ST_IDLE) & any_low;
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_src_d = fire ? gnt_src : last_src_q;
    case (state_q)
      ST_IDLE:  state_d = any_low ? ST_HOLD : ST_IDLE;
      ST_HOLD:  begin
        state_d = any_low ? ST_HOLD : ST_GUARD;
        cnt_d   = any_low ? cnt_q : LOCK_W'(LOCKOUT_CYCLES);
      end
      ST_GUARD: begin
        state_d = any_low ? ST_HOLD : (cnt_q == '0) ? ST_IDLE : ST_GUARD;
        cnt_d   = (any_low || cnt_q == '0) ? cnt_q : cnt_q - 1'b1;
      end
      default:  state_d = ST_IDLE;
    endcase
    cmd_valid_d = fire;
    cmd_code_d  = fire ? gnt_code : cmd_code_q;
    cmd_src_d   = fire ? gnt_src : cmd_src_q;
    cursor_d    = !fire                 ? cursor_q :
                  gnt_code == CMD_LEFT  ? ((cursor_q == '0) ? LAST : cursor_q - ONE) :
                  gnt_code == CMD_RIGHT ? ((cursor_q == LAST) ? '0 : cursor_q + ONE) :
                  gnt_code == CMD_RST   ? '0 : cursor_q;
    sel_item_d  = (fire && gnt_code == CMD_SEL) ? cursor_q :
                  (fire && gnt_code == CMD_RST) ? '0 : sel_item_q;
    sel_valid_d = (fire && gnt_code == CMD_SEL) ? 1'b1 :
                  (fire && gnt_code == CMD_RST) ? 1'b0 : sel_valid_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      last_src_q  <= SRC_IR;
      cmd_valid_q <= 1'b0;
      cmd_code_q  <= '0;
      cmd_src_q   <= 1'b0;
      cursor_q    <= '0;
      sel_item_q  <= '0;
      sel_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      last_src_q  <= last_src_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_code_q  <= cmd_code_d;
      cmd_src_q   <= cmd_src_d;
      cursor_q    <= cursor_d;
      sel_item_q  <= sel_item_d;
      sel_valid_q <= sel_valid_d;
    end
  end

  always_comb begin
    cmd_valid = cmd_valid_q;
    cmd_code  = cmd_code_q;
    cmd_src   = cmd_src_q;
    cursor    = cursor_q;
    sel_item  = sel_item_q;
    sel_valid = sel_valid_q;
    busy      = state_q != ST_IDLE;
  end
endmodule

// File: tb/tb_input_command_arbiter.sv
// tb_input_command_arbiter: scoreboard bench for the command arbiter, cursor and lockout
module tb_input_command_arbiter;
  localparam int NUM  = 5;
  localparam int LOCK = 4;
  localparam int GUARD_EXIT = LOCK + 2;

  typedef struct packed {
    logic [1:0] code;
    logic       src;
    logic [2:0] cur;
    logic [2:0] sel;
    logic       sv;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic ir_l = 1'b1, ir_r = 1'b1, ir_s = 1'b1, ir_x = 1'b1;
  logic b_l = 1'b1, b_r = 1'b1, b_s = 1'b1, b_x = 1'b1;
  logic       cmd_valid, cmd_src, sel_valid, busy;
  logic [1:0] cmd_code;
  logic [2:0] cursor, sel_item;

  exp_t sbq[$];
  int n_chk = 0, n_pass = 0, n_cmd = 0, n_push = 0;
  int m_cur = 0, m_sel = 0;
  logic m_sv = 1'b0, m_last = 1'b1;

  input_command_arbiter #(.NUM_ITEMS(NUM), .CUR_W(3), .LOCKOUT_CYCLES(LOCK), .LOCK_W(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .deb_ir_left(ir_l), .deb_ir_right(ir_r), .deb_ir_sel(ir_s), .deb_ir_rst(ir_x),
    .btn_left(b_l), .btn_right(b_r), .btn_sel(b_s), .btn_rst(b_x),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_src(cmd_src),
    .cursor(cursor), .sel_item(sel_item), .sel_valid(sel_valid), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic model_reset();
    m_cur = 0;
    m_sel = 0;
    m_sv = 1'b0;
    m_last = 1'b1;
  endtask

  task automatic push_cmd(input logic [1:0] code, input logic src);
    case (code)
      2'd0: m_cur = (m_cur == 0) ? NUM - 1 : m_cur - 1;
      2'd1: m_cur = (m_cur == NUM - 1) ? 0 : m_cur + 1;
      2'd2: begin m_sel = m_cur; m_sv = 1'b1; end
      default: begin m_cur = 0; m_sel = 0; m_sv = 1'b0; end
    endcase
    m_last = src;
    n_push++;
    sbq.push_back('{code: code, src: src, cur: 3'(m_cur), sel: 3'(m_sel), sv: m_sv});
  endtask

  task automatic set_line(input logic src, input logic [1:0] code, input logic v);
    if (src)
      case (code)
        2'd0: ir_l = v;
        2'd1: ir_r = v;
        2'd2: ir_s = v;
        default: ir_x = v;
      endcase
    else
      case (code)
        2'd0: b_l = v;
        2'd1: b_r = v;
        2'd2: b_s = v;
        default: b_x = v;
      endcase
  endtask

  task automatic wait_idle();
    int k = 0;
    while (busy && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk("idle_timeout", busy, 0);
  endtask

  task automatic measure_guard(input string tag);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 50);
    chk(tag, k, GUARD_EXIT);
  endtask

  task automatic press(input logic src, input logic [1:0] code, input int n);
    @(negedge clk);
    set_line(src, code, 1'b0);
    push_cmd(code, src);
    repeat (n) @(negedge clk);
    set_line(src, code, 1'b1);
    wait_idle();
  endtask

  task automatic tie();
    logic w;
    @(negedge clk);
    ir_s = 1'b0;
    b_l = 1'b0;
    w = m_last ? 1'b0 : 1'b1;
    push_cmd(w ? 2'd2 : 2'd0, w);
    repeat (2) @(negedge clk);
    ir_s = 1'b1;
    b_l = 1'b1;
    wait_idle();
  endtask

  always @(negedge clk) begin
    if (rst_n && cmd_valid) begin
      n_cmd++;
      if (sbq.size() == 0) chk("unexpected_cmd", 1, 0);
      else begin
        exp_t e;
        e = sbq.pop_front();
        chk("cmd_code", cmd_code, e.code);
        chk("cmd_src", cmd_src, e.src);
        chk("cursor", cursor, e.cur);
        chk("sel_item", sel_item, e.sel);
        chk("sel_valid", sel_valid, e.sv);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_cmd_valid", cmd_valid, 0);
    chk("rst_cursor", cursor, 0);
    chk("rst_sel_item", sel_item, 0);
    chk("rst_sel_valid", sel_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_cmd_src", cmd_src, 0);
    rst_n = 1'b1;
    // single button right press with latency, pulse width and guard length
    @(negedge clk);
    b_r = 1'b0;
    push_cmd(2'd1, 1'b0);
    @(negedge clk);
    chk("latency", cmd_valid, 1);
    @(negedge clk);
    chk("one_pulse", cmd_valid, 0);
    @(negedge clk);
    b_r = 1'b1;
    measure_guard("guard_len");
    // wraparound via IR left then five rights
    press(1'b1, 2'd3, 2);
    press(1'b1, 2'd0, 2);
    for (int i = 0; i < 5; i++) press(1'b0, 2'd1, 1 + (i % 3));
    // round-robin ties right after reset
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    tie();
    tie();
    // select then IR reset
    press(1'b0, 2'd0, 2);
    press(1'b0, 2'd2, 2);
    press(1'b1, 2'd3, 2);
    // re-press during guard restarts the lockout
    @(negedge clk);
    b_l = 1'b0;
    push_cmd(2'd0, 1'b0);
    repeat (2) @(negedge clk);
    b_l = 1'b1;
    repeat (3) @(negedge clk);
    b_l = 1'b0;
    @(negedge clk);
    chk("rehold_busy", busy, 1);
    b_l = 1'b1;
    measure_guard("guard_restart");
    // asynchronous reset while a button is held
    press(1'b1, 2'd2, 2);
    @(negedge clk);
    b_r = 1'b0;
    push_cmd(2'd1, 1'b0);
    repeat (2) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_busy", busy, 0);
    chk("arst_cmd_code", cmd_code, 0);
    chk("arst_sel_valid", sel_valid, 0);
    chk("arst_sel_item", sel_item, 0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    push_cmd(2'd1, 1'b0);
    @(negedge clk);
    chk("post_rst_fire", cmd_valid, 1);
    b_r = 1'b1;
    wait_idle();
    repeat (3) @(negedge clk);
    chk("sb_empty", sbq.size(), 0);
    chk("cmd_count", n_cmd, n_push);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
